writeback_unit: RTL

- Write-side controller for the 32x32 register file. It merges single-cycle ALU results and variable-latency, in-order load responses into a single register-file write per cycle.
- Keeps a per-register pending-load scoreboard that stalls decode on RAW and WAW hazards against outstanding loads.
- Sits between the execute/memory stages and the register file write port; drives regWrite/writeAddr/regWriteData.

---
 rtl/writeback_unit_pkg.sv | 24 ++
 rtl/wb_tag_fifo.sv | 65 ++++++
 rtl/writeback_unit.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/writeback_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : writeback_unit_pkg
// Description : Shared constants and types for the register-file writeback
//               controller (address width, default data width, x0, and the
//               per-cycle writeback source select).
// Revision    : 1.0 - initial release
// ============================================================================
package writeback_unit_pkg;

  localparam int REG_ADDR_W   = 5;
  localparam int DEFAULT_XLEN = 32;
  localparam logic [REG_ADDR_W-1:0] X0 = '0;

  // Which producer owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_SKID = 2'd2,
    WB_LOAD = 2'd3
  } wb_src_e;

endpackage : writeback_unit_pkg
`default_nettype wire

// File: rtl/wb_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_tag_fifo
// Description : In-order FIFO of load destination tags. DEPTH entries of
//               WIDTH bits with occupancy count; pointers wrap modulo DEPTH.
//               The caller must not push when full nor pop when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_tag_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 5,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Occupancy next-state: simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage and wrapping pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule : wb_tag_fifo
`default_nettype wire

// File: rtl/writeback_unit.sv
`default_nettype none
// ============================================================================
// Module      : writeback_unit
// Description : Register-file write-side controller. Merges ALU results and
//               in-order load responses into one write per cycle (priority
//               ALU > skid > live load response), tracks pending loads in a
//               per-register scoreboard and stalls decode on RAW/WAW hazards.
//               Optional macro WB_PROTO_CHK_EN enables the sticky protocol
//               error flag and drops pushes to already-pending registers.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter  int LD_DEPTH = 4,
  parameter  int XLEN     = DEFAULT_XLEN,
  localparam int CNT_W    = $clog2(LD_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  ld_issue,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  output logic                  ld_ready,
  input  logic                  ld_resp_valid,
  input  logic [XLEN-1:0]       ld_resp_data,
  output logic                  ld_resp_ready,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  output logic                  stall,
  output logic                  regWrite,
  output logic [REG_ADDR_W-1:0] writeAddr,
  output logic [XLEN-1:0]       regWriteData,
  output logic                  err
);

  localparam int NUM_REGS = 1 << REG_ADDR_W;

  // Registered state
  logic                  regWrite_q;
  logic [REG_ADDR_W-1:0] writeAddr_q;
  logic [XLEN-1:0]       regWriteData_q;
  logic                  skid_valid_q;
  logic [XLEN-1:0]       skid_data_q;
  logic [REG_ADDR_W-1:0] skid_rd_q;
  logic [NUM_REGS-1:0]   sb_q;
  logic [NUM_REGS-1:0]   sb_d;

  // Combinational
  wb_src_e               w_sel;
  logic                  w_fifo_empty;
  logic [REG_ADDR_W-1:0] w_head_rd;
  logic [CNT_W-1:0]      w_count;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_skid_capture;
  logic [REG_ADDR_W-1:0] w_wr_rd;
  logic [XLEN-1:0]       w_wr_data;

  wb_tag_fifo #(
    .DEPTH (LD_DEPTH),
    .WIDTH (REG_ADDR_W)
  ) u_tag_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (w_push),
    .data_i  (ld_rd),
    .pop_i   (w_pop),
    .data_o  (w_head_rd),
    .empty_o (w_fifo_empty),
    .count_o (w_count)
  );

  assign ld_ready      = (w_count != CNT_W'(LD_DEPTH));
  assign ld_resp_ready = ~skid_valid_q;

  // A push needs FIFO room; with checking enabled, a push to a register that
  // already has a load in flight is also refused (the scoreboard bit would
  // otherwise be cleared by the older load's retirement).
`ifdef WB_PROTO_CHK_EN
  assign w_push = ld_issue & ld_ready & ~((ld_rd != X0) & sb_q[ld_rd]);
`else
  assign w_push = ld_issue & ld_ready;
`endif

  // Source select and write-port mux; a retiring load pops the tag FIFO.
  always_comb begin
    w_sel          = WB_NONE;
    w_wr_rd        = X0;
    w_wr_data      = '0;
    w_skid_capture = 1'b0;
    if (alu_valid) begin
      w_sel     = WB_ALU;
      w_wr_rd   = alu_rd;
      w_wr_data = alu_data;
      // Response collides with the ALU: park it so memory is not stalled.
      w_skid_capture = ld_resp_valid & ~skid_valid_q & ~w_fifo_empty;
    end else if (skid_valid_q) begin
      w_sel     = WB_SKID;
      w_wr_rd   = skid_rd_q;
      w_wr_data = skid_data_q;
    end else if (ld_resp_valid && !w_fifo_empty) begin
      w_sel     = WB_LOAD;
      w_wr_rd   = w_head_rd;
      w_wr_data = ld_resp_data;
    end
    w_pop = (w_sel == WB_SKID) || (w_sel == WB_LOAD);
  end

  // Scoreboard next state: clear on retire, then set on issue so set wins.
  always_comb begin
    sb_d = sb_q;
    if (w_pop && (w_head_rd != X0)) sb_d[w_head_rd] = 1'b0;
    if (w_push && (ld_rd != X0))    sb_d[ld_rd]     = 1'b1;
  end

  // Decode hazard check against registered scoreboard only.
  always_comb begin
    stall = ((rs1_addr != X0) && sb_q[rs1_addr]) ||
            ((rs2_addr != X0) && sb_q[rs2_addr]) ||
            ((rd_addr  != X0) && sb_q[rd_addr]);
  end

  // Registered write port, skid register and scoreboard.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regWrite_q     <= 1'b0;
      writeAddr_q    <= X0;
      regWriteData_q <= '0;
      skid_valid_q   <= 1'b0;
      skid_data_q    <= '0;
      skid_rd_q      <= X0;
      sb_q           <= '0;
    end else begin
      regWrite_q <= (w_sel != WB_NONE) && (w_wr_rd != X0);
      if (w_sel != WB_NONE) begin
        writeAddr_q    <= w_wr_rd;
        regWriteData_q <= w_wr_data;
      end
      if (w_skid_capture) begin
        skid_valid_q <= 1'b1;
        skid_data_q  <= ld_resp_data;
        skid_rd_q    <= w_head_rd;
      end else if (w_sel == WB_SKID) begin
        skid_valid_q <= 1'b0;
      end
      sb_q <= sb_d;
    end
  end

  assign regWrite     = regWrite_q;
  assign writeAddr    = writeAddr_q;
  assign regWriteData = regWriteData_q;

`ifdef WB_PROTO_CHK_EN
  logic err_q;
  logic w_err_evt;

  assign w_err_evt = (ld_issue & ~ld_ready) |
                     (ld_resp_valid & w_fifo_empty) |
                     (alu_valid & (alu_rd != X0) & sb_q[alu_rd]) |
                     (ld_issue & (ld_rd != X0) & sb_q[ld_rd]);

  // Sticky protocol error; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_q | w_err_evt;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule : writeback_unit
`default_nettype wire
